seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Parametrised multiplexed seven-segment scanner. It is the successor to the fixed 3/4-digit digit-enable decoder.
- Time-multiplexes up to NUM_DIGITS hex digits onto one shared segment bus.
- Supports a runtime active-digit count and a programmable decimal-point position.
- Inserts an anti-ghosting blank interval between digits.
- Sits between the display-formatting logic and the board anode/cathode pins.

Parameters:
NUM_DIGITS, 8, number of physical digits (2..16)
CLK_DIV, 100000, clk cycles per digit slot (>=2)
BLANK_CYC, 2, cycles at the start of each slot with everything off (0..CLK_DIV-1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  capture strobe for digits/num_act/dp_pos/dp_en
digits  in  4*NUM_DIGITS  packed hex digits; [3:0] is digit 0 (rightmost)
num_act  in  $clog2(NUM_DIGITS+1)  number of active digits, counted from digit 0
dp_pos  in  $clog2(NUM_DIGITS)  digit index carrying the decimal point
dp_en  in  1  decimal point enable
an  out  NUM_DIGITS  one-hot digit enable, active-high
an_n  out  NUM_DIGITS  ~an
seg_n  out  7  cathodes a..g, active-low; seg_n[0]=a
dp_n  out  1  decimal point cathode, active-low
scan_idx  out  $clog2(NUM_DIGITS)  digit currently scanned
frame_done  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- Reset (async, rst_n=0) clears:
  - prescaler = 0, scan_idx = 0, state = IDLE, all shadow registers = 0
  - an = 0, an_n = all 1, seg_n = 7'h7F, dp_n = 1, frame_done = 0
- Shadow registers:
  - A clk edge with load=1 captures digits, num_act, dp_pos and dp_en.
  - num_act > NUM_DIGITS is clamped to NUM_DIGITS at capture.
  - The scan uses only shadow values. A new capture takes visible effect at the next slot boundary. Within the current SHOW slot, only the segment/dp data follow the new shadow value; the scan position does not change.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick = (prescaler == CLK_DIV-1); it is a free-running one-cycle pulse.
- FSM:
  - IDLE: all outputs off. On tick with shadow num_act != 0: scan_idx <= 0, go to BLANK.
  - BLANK: all outputs off. A blank counter counts BLANK_CYC cycles, then the FSM goes to SHOW. With BLANK_CYC = 0 the FSM goes from a tick straight to SHOW.
  - SHOW: an[scan_idx] = 1; seg_n = hex7seg(digit[scan_idx]); dp_n = ~(dp_en && dp_pos == scan_idx).
    On tick:
    - If num_act == 0: go to IDLE, scan_idx <= 0.
    - Else if scan_idx >= num_act-1: scan_idx <= 0, frame_done = 1 for that cycle, go to BLANK.
    - Else: scan_idx + 1, go to BLANK.
- Shrinking num_act mid-frame: the `>=` comparison forces a wrap on the next tick. An out-of-range index is never advanced.
- hex7seg (active-low gfedcba) for digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Outputs are combinational decodes of registered state, scan_idx and shadow; they have no glitch-free guarantee beyond that. an_n is always ~an.
- Lit time per digit = CLK_DIV-BLANK_CYC cycles. Frame period = num_act*CLK_DIV cycles.
- At most one an bit is high in any cycle.

Optional Feature:
SEG_LZ_BLANK_EN
- Defined: leading-zero blanking.
  - While in SHOW, digit i is blanked (seg_n = 7'h7F) when i > highest nonzero shadow digit index, i < num_act, and i > dp_pos when dp_en=1.
  - Digit 0 is never blanked. Anode and dp behaviour are unchanged.
- Undefined: all active digits are always displayed, including leading zeros.

Test Plan:
- Reset: CLK_DIV=4, BLANK_CYC=1. Hold rst_n=0 for 3 cycles -> an=0, an_n=8'hFF, seg_n=7'h7F, dp_n=1, scan_idx=0, frame_done=0.
- Scan: load digits=32'h0000_0321, num_act=3, dp_en=0 -> an sequence 01,02,04,01...
  - Each digit lit 3 of 4 cycles, blank 1.
  - seg_n = 79, 24, 30 for digits 0..2.
  - frame_done pulses every 12 cycles.
- Decimal point: num_act=4, dp_en=1, dp_pos=3 -> dp_n=0 only while an=8'h08; otherwise dp_n=1.
- Live shrink: num_act=8, load num_act=2 while scan_idx=5 -> next tick gives scan_idx=0 with frame_done=1; thereafter an alternates 01,02.
- Idle/clamp: load num_act=0 -> IDLE after the current slot, an=0. Then load num_act=15 with NUM_DIGITS=8 -> scans all 8 digits.
- Blanking (SEG_LZ_BLANK_EN defined): digits=32'h0000_0042, num_act=4, dp_en=0 -> digits 2,3 show seg_n=7F with an still asserted. Then dp_en=1, dp_pos=3 -> digits 2,3 show 40.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed seven-segment scanner with a per-slot anti-ghost blank interval.
// Optional leading-zero blanking is compiled in when SEG_LZ_BLANK_EN is defined.

module seg_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg_n
);
  logic [6:0] raw;

  always_comb begin
    raw = 7'h7F;
    case (nib)
      4'h0: raw = 7'h40;
      4'h1: raw = 7'h79;
      4'h2: raw = 7'h24;
      4'h3: raw = 7'h30;
      4'h4: raw = 7'h19;
      4'h5: raw = 7'h12;
      4'h6: raw = 7'h02;
      4'h7: raw = 7'h78;
      4'h8: raw = 7'h00;
      4'h9: raw = 7'h10;
      4'hA: raw = 7'h08;
      4'hB: raw = 7'h03;
      4'hC: raw = 7'h46;
      4'hD: raw = 7'h21;
      4'hE: raw = 7'h06;
      4'hF: raw = 7'h0E;
      default: raw = 7'h7F;
    endcase
  end

  assign seg_n = blank ? 7'h7F : raw;
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV    = 100000,
  parameter int BLANK_CYC  = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              load,
  input  logic [4*NUM_DIGITS-1:0]           digits,
  input  logic [$clog2(NUM_DIGITS+1)-1:0]   num_act,
  input  logic [$clog2(NUM_DIGITS)-1:0]     dp_pos,
  input  logic                              dp_en,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [NUM_DIGITS-1:0]             an_n,
  output logic [6:0]                        seg_n,
  output logic                              dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0]     scan_idx,
  output logic                              frame_done
);
  localparam int NA_W  = $clog2(NUM_DIGITS+1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(CLK_DIV);

  localparam logic [PW-1:0]   PRE_LAST   = PW'(CLK_DIV-1);
  localparam logic [PW-1:0]   BLANK_LAST = PW'((BLANK_CYC > 0) ? BLANK_CYC-1 : 0);
  localparam logic [NA_W-1:0] NA_MAX     = NA_W'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam state_t SLOT_ST = state_t'((BLANK_CYC == 0) ? SHOW : BLANK);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NA_W-1:0]            num_act;
    logic [IDX_W-1:0]           dp_pos;
    logic                       dp_en;
  } shadow_t;

  shadow_t          sh;
  state_t           state, state_d;
  logic [PW-1:0]    presc, bcnt, bcnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             fd_d;
  logic             tick, showing, last_slot;

  // Shadow capture; out-of-range active counts saturate to the physical digit count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh <= '0;
    end else if (load) begin
      sh.digits  <= digits;
      sh.num_act <= (num_act > NA_MAX) ? NA_MAX : num_act;
      sh.dp_pos  <= dp_pos;
      sh.dp_en   <= dp_en;
    end
  end

  assign tick = (presc == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + PW'(1);
  end

  // >= rather than == so a shrunken num_act forces a wrap instead of running on
  assign last_slot = (NA_W'(scan_idx) + NA_W'(1)) >= sh.num_act;

  always_comb begin
    state_d = state;
    idx_d   = scan_idx;
    bcnt_d  = bcnt;
    fd_d    = 1'b0;
    case (state)
      IDLE: begin
        if (tick && sh.num_act != '0) begin
          idx_d   = '0;
          bcnt_d  = '0;
          state_d = SLOT_ST;
        end
      end
      BLANK: begin
        if (bcnt == BLANK_LAST) state_d = SHOW;
        else                    bcnt_d  = bcnt + PW'(1);
      end
      SHOW: begin
        if (tick) begin
          bcnt_d = '0;
          if (sh.num_act == '0) begin
            idx_d   = '0;
            state_d = IDLE;
          end else if (last_slot) begin
            idx_d   = '0;
            fd_d    = 1'b1;
            state_d = SLOT_ST;
          end else begin
            idx_d   = scan_idx + IDX_W'(1);
            state_d = SLOT_ST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      scan_idx   <= '0;
      bcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      scan_idx   <= idx_d;
      bcnt       <= bcnt_d;
      frame_done <= fd_d;
    end
  end

  logic [NUM_DIGITS-1:0] lz_blank;

`ifdef SEG_LZ_BLANK_EN
  // zero_above[i]: every shadow digit from i upward is zero
  logic [NUM_DIGITS:1] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  assign lz_blank[0] = 1'b0;
  for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
    assign zero_above[i] = zero_above[i+1] & ~(|sh.digits[i]);
    assign lz_blank[i]   = zero_above[i] && (NA_W'(i) < sh.num_act) &&
                           (!sh.dp_en || (IDX_W'(i) > sh.dp_pos));
  end
`else
  assign lz_blank = '0;
`endif

  logic [NUM_DIGITS-1:0][6:0] lane_seg;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    seg_digit u_dig (
      .nib   (sh.digits[i]),
      .blank (lz_blank[i]),
      .seg_n (lane_seg[i])
    );
  end

  assign showing = (state == SHOW);
  assign an      = showing ? (NUM_DIGITS'(1) << scan_idx) : '0;
  assign an_n    = ~an;
  assign seg_n   = showing ? lane_seg[scan_idx] : 7'h7F;
  assign dp_n    = ~(showing && sh.dp_en && (sh.dp_pos == scan_idx));
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: slot-level reference model plus directed and randomized scenarios.
module tb_seg_scan_ctrl;
  localparam int ND = 8;
  localparam int CD = 4;
  localparam int BC = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [31:0] digits = '0;
  logic [3:0]  num_act = '0;
  logic [2:0]  dp_pos = '0;
  logic        dp_en = 1'b0;
  logic [7:0]  an, an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [2:0]  scan_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits(digits), .num_act(num_act),
    .dp_pos(dp_pos), .dp_en(dp_en), .an(an), .an_n(an_n), .seg_n(seg_n),
    .dp_n(dp_n), .scan_idx(scan_idx), .frame_done(frame_done)
  );

  // Slot-level model: time within a slot, which digit the slot belongs to, shadow copy
  int          m_presc, m_idx, m_na, m_dpp;
  bit          m_act, m_fd, m_dpe;
  logic [31:0] m_dig;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc = 0; m_idx = 0; m_na = 0; m_dpp = 0;
      m_act = 0; m_fd = 0; m_dpe = 0; m_dig = '0;
    end else begin
      m_fd = 0;
      if (m_presc == CD-1) begin
        if (!m_act) begin
          if (m_na != 0) begin m_act = 1; m_idx = 0; end
        end else if (m_na == 0) begin
          m_act = 0; m_idx = 0;
        end else if (m_idx + 1 >= m_na) begin
          m_idx = 0; m_fd = 1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
      if (load) begin
        m_dig = digits;
        m_na  = (int'(num_act) > ND) ? ND : int'(num_act);
        m_dpp = int'(dp_pos);
        m_dpe = dp_en;
      end
      m_presc = (m_presc + 1) % CD;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[v];
  endfunction

  function automatic bit lz_blank(input int i);
`ifdef SEG_LZ_BLANK_EN
    int hz = -1;
    for (int j = 0; j < ND; j++) if (m_dig[4*j +: 4] != 4'h0) hz = j;
    return (i != 0) && (i > hz) && (i < m_na) && (!m_dpe || i > m_dpp);
`else
    return (i < 0);
`endif
  endfunction

  // {an, an_n, seg_n, dp_n, scan_idx, frame_done}
  function automatic logic [27:0] expv();
    bit         lit = m_act && (m_presc >= BC);
    logic [7:0] a   = lit ? 8'(1 << m_idx) : 8'h00;
    logic [6:0] s   = 7'h7F;
    logic       d   = !(lit && m_dpe && (m_dpp == m_idx));
    if (lit && !lz_blank(m_idx)) s = hex7(m_dig[4*m_idx +: 4]);
    return {a, ~a, s, d, 3'(m_idx), m_fd};
  endfunction

  task automatic put(input logic [31:0] d, input int na, input int dpp, input bit dpe);
    digits = d; num_act = 4'(na); dp_pos = 3'(dpp); dp_en = dpe; load = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== {8'h00, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done},
               {8'h00, 8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0});
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (an !== 8'h00 || seg_n !== 7'h7F) begin
        errors++; $display("FAIL reset_idle: an=%h seg_n=%h required 00/7f", an, seg_n);
      end
    end
  endtask

  task automatic test_scan();
    int last_fd = -1, nfd = 0, lit_cnt = 0;
    logic [6:0] want;
    put(32'h0000_0321, 3, 0, 0);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv()) begin
        errors++; $display("FAIL scan_model: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      load = 1'b0;
      if (an != 8'h00) begin
        want = (an == 8'h01) ? 7'h79 : (an == 8'h02) ? 7'h24 : (an == 8'h04) ? 7'h30 : 7'h7F;
        checks++;
        if (seg_n !== want || want == 7'h7F) begin
          errors++; $display("FAIL scan_seg: an=%h seg_n=%h required %h", an, seg_n, want);
        end
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          checks++;
          if (c - last_fd != 12 || lit_cnt != 9) begin
            errors++; $display("FAIL scan_frame: period %0d lit %0d required 12/9", c - last_fd, lit_cnt);
          end
        end
        last_fd = c; nfd++; lit_cnt = 0;
      end
      if (an != 8'h00) lit_cnt++;
    end
    checks++;
    if (nfd < 3) begin errors++; $display("FAIL scan_fd_count: got %0d required >=3", nfd); end
  endtask

  task automatic test_dp();
    bit seen = 0;
    put(32'h0000_4321, 4, 3, 1);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv()) begin
        errors++; $display("FAIL dp_model: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      load = 1'b0;
      checks++;
      if (dp_n !== (an == 8'h08 ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL dp_pos: an=%h dp_n=%b", an, dp_n);
      end
      if (an == 8'h08) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL dp_digit3_seen: got 0 required 1"); end
  endtask

  task automatic test_shrink();
    bit found = 0;
    logic [1:0] seen = '0;
    put(32'h8765_4321, 8, 0, 0);
    for (int c = 0; c < 120 && !found; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv()) begin
        errors++; $display("FAIL shrink_model: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      load = 1'b0;
      if (scan_idx == 3'd5) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL shrink_reach5: timeout waiting for scan_idx 5"); return; end
    put(32'h8765_4321, 2, 0, 0);
    found = 0;
    for (int c = 0; c < 2*CD+2 && !found; c++) begin
      @(negedge clk);
      load = 1'b0;
      if (frame_done) found = 1;
    end
    checks++;
    if (!found || scan_idx !== 3'd0) begin
      errors++; $display("FAIL shrink_wrap: frame_done=%b scan_idx=%0d required 1/0", found, scan_idx);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv() || an > 8'h02) begin
        errors++; $display("FAIL shrink_alt: an=%h got %h required %h", an, {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      seen |= an[1:0];
    end
    checks++;
    if (seen !== 2'b11) begin errors++; $display("FAIL shrink_seen: got %b required 11", seen); end
  endtask

  task automatic test_idle_clamp();
    logic [7:0] seen = '0;
    put(32'h1111_1111, 0, 0, 0);
    for (int c = 0; c < 2*CD+1; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv()) begin
        errors++; $display("FAIL idle_model: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      load = 1'b0;
    end
    for (int c = 0; c < 3*CD; c++) begin
      @(negedge clk);
      checks++;
      if (an !== 8'h00 || scan_idx !== 3'd0) begin
        errors++; $display("FAIL idle_off: an=%h scan_idx=%0d required 00/0", an, scan_idx);
      end
    end
    put($urandom, 15, 0, 0);
    for (int c = 0; c < 2*ND*CD + CD; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv()) begin
        errors++; $display("FAIL clamp_model: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      load = 1'b0;
      seen |= an;
    end
    checks++;
    if (seen !== 8'hFF) begin errors++; $display("FAIL clamp_all: got %h required ff", seen); end
  endtask

  task automatic test_lz();
    logic [6:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) put(32'h0000_0042, 4, 0, 0);
      else           put(32'h0000_0042, 4, 3, 1);
`ifdef SEG_LZ_BLANK_EN
      want = (pass == 0) ? 7'h7F : 7'h40;
`else
      want = 7'h40;
`endif
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        checks++;
        if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv()) begin
          errors++; $display("FAIL lz_model: got %h required %h", {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
        end
        load = 1'b0;
        if (c >= CD && (an == 8'h04 || an == 8'h08)) begin
          checks++;
          if (seg_n !== want) begin errors++; $display("FAIL lz_upper: an=%h seg_n=%h required %h", an, seg_n, want); end
        end
        if (c >= CD && an == 8'h01) begin
          checks++;
          if (seg_n !== 7'h24) begin errors++; $display("FAIL lz_digit0: seg_n=%h required 24", seg_n); end
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if ({an, an_n, seg_n, dp_n, scan_idx, frame_done} !== expv() || !$onehot0(an)) begin
        errors++; $display("FAIL random_model: cyc %0d got %h required %h", c, {an, an_n, seg_n, dp_n, scan_idx, frame_done}, expv());
      end
      load = 1'b0;
      if ($urandom_range(0, 15) == 0)
        put($urandom, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_dp();
    test_shrink();
    test_idle_clamp();
    test_lz();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
